// File: rtl/par2ser_if.sv
// rtl/par2ser_if.sv - load handshake and serial beat bundle for par2ser
interface par2ser_if #(
  parameter int PW = 64,
  parameter int SW = 1
);
  logic [PW-1:0] din;
  logic          load;
  logic          ready;
  logic          lsbfirst;
  logic          en;
  logic [SW-1:0] dout;
  logic          shift;
  logic          first;
  logic          last;
  logic          busy;
  logic          order;

  modport master (
    output din, load, lsbfirst, en,
    input  ready, dout, shift, first, last, busy, order
  );

  modport slave (
    input  din, load, lsbfirst, en,
    output ready, dout, shift, first, last, busy, order
  );
endinterface

// File: rtl/par2ser.sv
// rtl/par2ser.sv - parallel-to-serial shifter with valid/ready load and first/last framing
module par2ser #(
  parameter int PW = 64,
  parameter int SW = 1,
  parameter int CW = $clog2(PW / SW)
) (
  input  logic     clk,
  input  logic     reset,
  par2ser_if.slave bus
);
  localparam int NB   = PW / SW;
  localparam int CNTW = (CW < 1) ? 1 : CW;
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NB - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state, state_n;
  logic [PW-1:0]   sreg, sreg_n;
  logic [PW-1:0]   sreg_msb_adv, sreg_lsb_adv;
  logic [CNTW-1:0] count, count_n;
  logic            order_q, order_n;
  logic            busy, shift, at_last, accept;

  // A single-beat word has nothing left to shift, so the advanced value is all zeros.
  generate
    if (NB == 1) begin : g_single_beat
      assign sreg_msb_adv = '0;
      assign sreg_lsb_adv = '0;
    end else begin : g_multi_beat
      assign sreg_msb_adv = {sreg[PW-SW-1:0], {SW{1'b0}}};
      assign sreg_lsb_adv = {{SW{1'b0}}, sreg[PW-1:SW]};
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sreg    <= '0;
      count   <= '0;
      order_q <= 1'b0;
    end else begin
      state   <= state_n;
      sreg    <= sreg_n;
      count   <= count_n;
      order_q <= order_n;
    end
  end

  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    count_n = count;
    order_n = order_q;
    busy    = (state == SHIFT);
    shift   = busy & bus.en;
    at_last = shift & (count == LAST_CNT);
    accept  = bus.load & (~busy | at_last);

    case (state)
      IDLE:    if (accept) state_n = SHIFT;
      SHIFT:   if (at_last && !accept) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // A load taken on the last beat wins over that beat's shift update.
    if (accept) begin
      sreg_n  = bus.din;
      order_n = bus.lsbfirst;
      count_n = '0;
    end else if (shift) begin
      sreg_n  = order_q ? sreg_lsb_adv : sreg_msb_adv;
      count_n = at_last ? '0 : count + 1'b1;
    end
  end

  assign bus.ready = ~busy | at_last;
  assign bus.dout  = order_q ? sreg[SW-1:0] : sreg[PW-1:PW-SW];
  assign bus.shift = shift;
  assign bus.first = shift & (count == '0);
  assign bus.last  = at_last;
  assign bus.busy  = busy;
  assign bus.order = order_q;
endmodule
